// File: rtl/phase_frame_tx_pkg.sv
// rtl/phase_frame_tx_pkg.sv - shared types and constants for the phase-mean frame transmitter
package phase_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      SEQ  = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4
   } state_t;

   localparam int          N_CH          = 6;
   localparam int          DATA_BYTES    = 2 * N_CH;
   localparam int          FRAME_LEN     = DATA_BYTES + 3;
   localparam int          SNAP_W        = 16 * N_CH;
   localparam logic [3:0]  LAST_IDX      = 4'(DATA_BYTES - 1);
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/phase_frame_byte_mux.sv
// rtl/phase_frame_byte_mux.sv - selects one snapshot byte by index, channel 1 MSB byte at index 0
module phase_frame_byte_mux
   import phase_frame_tx_pkg::*;
(
   input  logic [SNAP_W-1:0] snap,
   input  logic [3:0]        idx,
   output logic [7:0]        data
);

   always_comb begin
      data = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (idx == 4'(i)) begin
            data = snap[SNAP_W-1-8*i -: 8];
         end
      end
   end

endmodule

// File: rtl/phase_frame_tx.sv
// rtl/phase_frame_tx.sv - snapshots six phase means on capture and streams them as a
// 15-byte framed packet (sync, seq, 12 data bytes, xor checksum) over valid/ready
module phase_frame_tx
   import phase_frame_tx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         OVR_W     = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    capture,
   input  logic signed [15:0]      phase_1,
   input  logic signed [15:0]      phase_2,
   input  logic signed [15:0]      phase_3,
   input  logic signed [15:0]      phase_4,
   input  logic signed [15:0]      phase_5,
   input  logic signed [15:0]      phase_6,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic [7:0]              seq_num,
   output logic [OVR_W-1:0]        ovr_count
);

   state_t              state, state_n;
   logic [3:0]          idx, idx_n, mux_idx;
   logic [SNAP_W-1:0]   snap, snap_n;
   logic [7:0]          csum, csum_n;
   logic [7:0]          seq_n, tx_data_n, mux_data;
   logic                tx_valid_n;
   logic [OVR_W-1:0]    ovr_n;
   logic                hs, accept;

   assign hs      = tx_valid && tx_ready;
   // a capture is taken when idle, or when it coincides with the checksum handshake
   assign accept  = capture && ((state == IDLE) || ((state == CSUM) && hs));
   assign busy    = (state != IDLE);
   // the byte loaded on the next handshake: index 0 after SEQ, idx+1 within DATA
   assign mux_idx = (state == DATA) ? (idx + 4'd1) : 4'd0;

   phase_frame_byte_mux u_byte_mux (
      .snap (snap),
      .idx  (mux_idx),
      .data (mux_data)
   );

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      snap_n     = snap;
      csum_n     = csum;
      seq_n      = seq_num;
      tx_data_n  = tx_data;
      tx_valid_n = tx_valid;
      ovr_n      = ovr_count;

      if (capture && !accept && (ovr_count != {OVR_W{1'b1}})) begin
         ovr_n = ovr_count + OVR_W'(1);
      end

      case (state)
         IDLE: ;
         SYNC: begin
            if (hs) begin
               state_n   = SEQ;
               tx_data_n = seq_num;
            end
         end
         SEQ: begin
            if (hs) begin
               state_n   = DATA;
               idx_n     = 4'd0;
               csum_n    = csum ^ tx_data;
               tx_data_n = mux_data;
            end
         end
         DATA: begin
            if (hs) begin
               csum_n = csum ^ tx_data;
               if (idx == LAST_IDX) begin
                  state_n   = CSUM;
                  tx_data_n = csum ^ tx_data;
               end else begin
                  idx_n     = idx + 4'd1;
                  tx_data_n = mux_data;
               end
            end
         end
         CSUM: begin
            if (hs) begin
               seq_n      = seq_num + 8'd1;
               state_n    = IDLE;
               tx_valid_n = 1'b0;
            end
         end
         default: begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
         end
      endcase

      // overrides the CSUM return-to-idle so back-to-back frames have no gap
      if (accept) begin
         snap_n     = {phase_1, phase_2, phase_3, phase_4, phase_5, phase_6};
         csum_n     = 8'd0;
         idx_n      = 4'd0;
         state_n    = SYNC;
         tx_data_n  = SYNC_BYTE;
         tx_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= 4'd0;
         snap      <= '0;
         csum      <= 8'd0;
         seq_num   <= 8'd0;
         tx_data   <= 8'd0;
         tx_valid  <= 1'b0;
         ovr_count <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         snap      <= snap_n;
         csum      <= csum_n;
         seq_num   <= seq_n;
         tx_data   <= tx_data_n;
         tx_valid  <= tx_valid_n;
         ovr_count <= ovr_n;
      end
   end

endmodule

// File: tb/tb_phase_frame_tx.sv
// tb/tb_phase_frame_tx.sv - table-driven and scoreboard bench for phase_frame_tx
module tb_phase_frame_tx;
   import phase_frame_tx_pkg::*;

   typedef struct {
      logic [15:0] p [6];
      logic [7:0]  seq;
      logic [7:0]  csum;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        capture = 1'b0;
   logic        tx_ready = 1'b1;
   logic [15:0] ph [6];
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic [7:0]  seq_num;
   logic [7:0]  ovr_count;

   int          vectors = 0;
   int          miscompares = 0;
   int          accepted = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  exp_seq;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'd0;
   logic        seen_valid = 1'b0;
   logic        seen_busy = 1'b0;
   vec_t        tbl [4];
   logic [15:0] pv [6];
   logic [15:0] basic [6];

   always #5 clock = ~clock;

   phase_frame_tx #(.SYNC_BYTE(8'hA5), .OVR_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .capture   (capture),
      .phase_1   (ph[0]),
      .phase_2   (ph[1]),
      .phase_3   (ph[2]),
      .phase_4   (ph[3]),
      .phase_5   (ph[4]),
      .phase_6   (ph[5]),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .seq_num   (seq_num),
      .ovr_count (ovr_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // one clock: sample and score at the falling edge, return just after the rising edge
   task automatic tick();
      @(negedge clock);
      seen_valid = tx_valid;
      seen_busy  = busy;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got %0h, expected no handshake", tx_data);
            end else begin
               check($sformatf("byte%0d", accepted), 32'(tx_data), 32'(exp_q.pop_front()));
               accepted++;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] calc_csum(input logic [15:0] p [6], input logic [7:0] s);
      logic [7:0] c = s;
      for (int i = 0; i < 6; i++) c = c ^ p[i][15:8] ^ p[i][7:0];
      return c;
   endfunction

   task automatic start_frame(input logic [15:0] p [6], input logic [7:0] s, input logic [7:0] c);
      exp_q.push_back(SYNC_BYTE_DEF);
      exp_q.push_back(s);
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(p[i][15:8]);
         exp_q.push_back(p[i][7:0]);
      end
      exp_q.push_back(c);
      ph = p;
      capture = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   // run until the scoreboard empties; optional stall at a byte position and a stray capture
   task automatic drain(input int budget, input int stall_pos, input int stall_len,
                        input logic [7:0] stall_byte, input int cap_tick);
      int n = 0;
      int stalls = 0;
      int base = accepted;
      while (exp_q.size() != 0 && n < budget) begin
         tx_ready = !((accepted - base == stall_pos) && (stalls < stall_len));
         if (!tx_ready) stalls++;
         capture = (n == cap_tick);
         tick();
         n++;
         if (!tx_ready) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(stall_byte));
         end
      end
      capture  = 1'b0;
      tx_ready = 1'b1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      basic = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C};
      tbl[0].p = basic;                                                         tbl[0].seq = 8'h00; tbl[0].csum = 8'h0C;
      tbl[1].p = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[1].seq = 8'h01; tbl[1].csum = 8'h01;
      tbl[2].p = '{16'h8000, 16'h7FFF, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF}; tbl[2].seq = 8'h02; tbl[2].csum = 8'h42;
      tbl[3].p = '{16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555}; tbl[3].seq = 8'h03; tbl[3].csum = 8'h03;
      ph = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

      repeat (2) @(posedge clock);
      #1;
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_seq_num", 32'(seq_num), 32'd0);
      check("rst_ovr_count", 32'(ovr_count), 32'd0);
      reset = 1'b0;
      tick();

      // table frames: 15 consecutive valid bytes one cycle after capture, then idle
      for (int v = 0; v < 4; v++) begin
         check("pre_seq_num", 32'(seq_num), 32'(tbl[v].seq));
         start_frame(tbl[v].p, tbl[v].seq, tbl[v].csum);
         for (int k = 0; k < FRAME_LEN; k++) begin
            tick();
            check($sformatf("run_valid%0d", k), 32'(seen_valid), 32'd1);
         end
         tick();
         check("end_valid", 32'(seen_valid), 32'd0);
         check("end_busy", 32'(seen_busy), 32'd0);
         check("end_queue", 32'(exp_q.size()), 32'd0);
      end
      check("seq_after_table", 32'(seq_num), 32'd4);
      exp_seq = 8'd4;

      // backpressure on byte position 5 (data 0x04) for three cycles
      start_frame(basic, exp_seq, calc_csum(basic, exp_seq));
      drain(100, 5, 3, 8'h04, -1);
      exp_seq++;

      // overrun: stray capture mid-frame with different inputs
      pv = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      start_frame(pv, exp_seq, calc_csum(pv, exp_seq));
      ph = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      drain(100, -1, 0, 8'h00, 6);
      exp_seq++;
      check("ovr_count_1", 32'(ovr_count), 32'd1);
      repeat (5) tick();
      check("ovr_idle_busy", 32'(busy), 32'd0);
      check("ovr_idle_valid", 32'(tx_valid), 32'd0);

      // back-to-back: capture coincides with the checksum handshake
      start_frame(basic, exp_seq, calc_csum(basic, exp_seq));
      exp_seq++;
      for (int n = 0; n < 40 && exp_q.size() > 1; n++) tick();
      check("b2b_at_csum", 32'(exp_q.size()), 32'd1);
      pv = '{16'hDEAD, 16'hBEEF, 16'h0001, 16'h8001, 16'h7F00, 16'h00FF};
      start_frame(pv, exp_seq, calc_csum(pv, exp_seq));
      exp_seq++;
      for (int k = 0; k < FRAME_LEN; k++) begin
         tick();
         check($sformatf("b2b_valid%0d", k), 32'(seen_valid), 32'd1);
      end
      tick();
      check("b2b_end_valid", 32'(seen_valid), 32'd0);
      check("b2b_queue", 32'(exp_q.size()), 32'd0);
      check("b2b_ovr", 32'(ovr_count), 32'd1);
      check("b2b_seq_num", 32'(seq_num), 32'(exp_seq));

      // asynchronous reset while DATA index 5 is presented
      start_frame(basic, exp_seq, calc_csum(basic, exp_seq));
      begin
         int base = accepted;
         for (int n = 0; n < 40 && (accepted - base) < 7; n++) tick();
      end
      check("pre_rst_valid", 32'(tx_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(tx_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_seq", 32'(seq_num), 32'd0);
      check("mid_rst_ovr", 32'(ovr_count), 32'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_seq = 8'd0;

      // 256 frames from reset: seq bytes 0x00..0xFF, then wrap to 0x00
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 6; i++) pv[i] = 16'($urandom_range(0, 65535));
         start_frame(pv, exp_seq, calc_csum(pv, exp_seq));
         drain(100, -1, 0, 8'h00, -1);
         exp_seq++;
      end
      tick();
      check("wrap_seq_num", 32'(seq_num), 32'd0);
      start_frame(basic, exp_seq, calc_csum(basic, exp_seq));
      drain(100, -1, 0, 8'h00, -1);
      tick();
      check("post_wrap_seq_num", 32'(seq_num), 32'd1);
      check("final_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/phase_frame_tx.md
Name: phase_frame_tx

Overview:
- Reader/consumer end of the six-channel phase-mean outputs.
- On a capture strobe, snapshots the six signed 16-bit phase means.
- Serialises the snapshot as one framed byte stream (sync, sequence, 12 data bytes, XOR checksum) over a valid/ready byte interface toward the host link (UART/FIFO bridge).
- Sits between the phase-mean accumulator and the host-side transport.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
OVR_W, 8, width of the overrun counter (saturating)

Ports:
clock  in  1  global clock
reset  in  1  global reset, asynchronous, active-high
capture  in  1  one-cycle strobe: new phase means valid on phase_1..phase_6
phase_1  in  16  signed phase mean channel 1
phase_2  in  16  signed phase mean channel 2
phase_3  in  16  signed phase mean channel 3
phase_4  in  16  signed phase mean channel 4
phase_5  in  16  signed phase mean channel 5
phase_6  in  16  signed phase mean channel 6
tx_data  out  8  current frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
busy  out  1  frame in progress (state != IDLE)
seq_num  out  8  sequence number of next frame to be captured
ovr_count  out  OVR_W  captures dropped while busy, saturating

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: tx_data=0, tx_valid=0, busy=0, seq_num=0, ovr_count=0, state=IDLE, snapshot registers=0, checksum=0.
- Reset mid-frame aborts immediately: tx_valid falls asynchronously, no partial frame resumes.
- Frame is 15 bytes, in order:
  - SYNC_BYTE
  - seq
  - phase_1[15:8], phase_1[7:0], ..., phase_6[15:8], phase_6[7:0]
  - CSUM = XOR of seq and the 12 data bytes (SYNC excluded)
- States: IDLE, SYNC, SEQ, DATA, CSUM.
  - DATA uses a 4-bit byte index 0..11 that selects the snapshot byte, MSB byte first.
- IDLE:
  - capture=1 → latch all six inputs in that cycle and latch seq; go to SYNC.
  - tx_valid=1 with tx_data=SYNC_BYTE from the next cycle (latency 1).
- SYNC → SEQ → DATA(0..11) → CSUM. Each advance happens only on the handshake (tx_valid && tx_ready).
- tx_data and tx_valid are registered.
- While tx_valid=1 and tx_ready=0, tx_data holds stable; tx_valid never drops before the handshake.
- Checksum register:
  - cleared at capture;
  - XORed with each seq/data byte as it is accepted;
  - CSUM state presents the register value.
- CSUM accepted:
  - seq_num increments modulo 256 (0xFF → 0x00);
  - return to IDLE, tx_valid=0 next cycle.
- Back-to-back: capture=1 in the same cycle CSUM is accepted is taken as a new frame. Go directly to SYNC with the new snapshot and seq+1; tx_valid stays 1 with no gap.
- capture=1 in any other busy cycle:
  - snapshot and frame are unaffected;
  - ovr_count increments, saturating at all-ones.
- Inputs are only sampled on an accepted capture; changes at other times have no effect.
- ovr_count clears only on reset.

Decomposition:
- Shared package: state encoding constants (IDLE..CSUM), FRAME_LEN=15, N_CH=6, SYNC_BYTE default.
- One natural sub-module: phase_frame_byte_mux, a combinational selection of snapshot byte by index. Keep it inline unless reused by a future receiver-side checker.

Test Plan:
- Basic frame: phase_1..6 = 0x0102, 0x0304, 0x0506, 0x0708, 0x090A, 0x0B0C, tx_ready=1, capture one cycle → bytes A5 00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0C on 15 consecutive cycles starting 1 cycle after capture; seq_num=1 afterwards; busy low after last byte.
- Backpressure: same stimulus, tx_ready=0 for 3 cycles when byte 0x04 is presented → tx_data=0x04 and tx_valid=1 held all 3 cycles; stream order unchanged; checksum still 0x0C.
- Negative/overrun: phase_1=16'hFFFF, others 0, capture; second capture mid-frame → first frame bytes A5 00 FF FF 00×10 then CSUM 0x00; ovr_count=1; no second frame.
- Back-to-back: capture asserted in the cycle the CSUM byte handshakes → second frame's A5 follows with no idle cycle; seq byte 0x01; ovr_count stays 0.
- Sequence wrap: 256 consecutive frames → 256th frame seq byte 0xFF, next frame 0x00; seq_num=0x00 after the 256th completes.
- Reset mid-frame: assert reset during DATA byte index 5 → tx_valid=0 and busy=0 immediately (before next clock edge); seq_num=0, ovr_count=0. Next capture produces a full frame with seq 0x00.
